seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_pkg.sv | 14 +
 rtl/seg7_scan_if.sv | 25 ++
 rtl/seg7_scan_decode.sv | 11 +
 rtl/seg7_scan.sv | 100 ++++++++++
 tb/tb_seg7_scan.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scanner.
// Glyphs are active-low, segments g..a on bits 6..0.
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    // Entry n holds the glyph for hex digit n (listed here from F down to 0).
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_scan_if.sv
// Host-side bundle for the scanner: display data toward the block,
// scan pattern back from it.
interface seg7_scan_if;
    import seg7_pkg::*;

    logic [4*NUM_DIGITS-1:0] disp_value;
    logic                    disp_load;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    blank_lz;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    scan_tick;

    modport master (
        output disp_value, disp_load, dp_mask, blank_lz,
        input  an_n, seg_n, dp_n, scan_tick
    );

    modport slave (
        input  disp_value, disp_load, dp_mask, blank_lz,
        output an_n, seg_n, dp_n, scan_tick
    );

endinterface

// File: rtl/seg7_scan_decode.sv
// Combinational hex-nibble to active-low seven-segment glyph lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb seg_n = GLYPH_TABLE[nibble];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver with a blank dead-time
// slot at the start of every digit, leading-zero blanking and decimal points.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    SYS_reset,
    input  logic [4*NUM_DIGITS-1:0] disp_value,
    input  logic                    disp_load,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    scan_tick
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]          cnt;
    logic [IDX_W-1:0]          idx;
    logic [4*NUM_DIGITS-1:0]   value_sh;
    logic [NUM_DIGITS-1:0]     dp_sh;
    logic                      blank_sh;

    logic                      slot_end;
    logic                      dead_time;
    logic [3:0]                cur_nibble;
    logic [6:0]                glyph;
    logic                      upper_nz;
    logic                      lz_blank;

    assign slot_end   = (cnt == CNT_LAST);
    assign dead_time  = (cnt == '0);
    assign cur_nibble = value_sh[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg_n  (glyph)
    );

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) >= idx && value_sh[4*i +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        lz_blank = blank_sh && (idx != '0) && !upper_nz;
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            cnt       <= '0;
            idx       <= '0;
            scan_tick <= 1'b0;
        end else begin
            cnt       <= slot_end ? '0 : cnt + 1'b1;
            scan_tick <= slot_end;
            if (slot_end) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            value_sh <= '0;
            dp_sh    <= '0;
            blank_sh <= 1'b0;
        end else if (disp_load) begin
            value_sh <= disp_value;
            dp_sh    <= dp_mask;
            blank_sh <= blank_lz;
        end
    end

    // Outputs are built from the pre-edge slot state, so a new load shows one edge later.
    always_ff @(posedge clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else if (dead_time) begin
            an_n  <= '1;
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= ~(NUM_DIGITS'(1) << idx);
            seg_n <= lz_blank ? SEG_BLANK : glyph;
            dp_n  <= lz_blank | ~dp_sh[idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at REFRESH_DIV=4: stimulus queues expected
// per-cycle outputs, a negedge monitor compares whatever is due that cycle.
module tb_seg7_scan;

    typedef struct {
        int         cyc;
        bit [127:0] name;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    logic clk;
    logic SYS_reset;
    int   cyc;
    int   base;
    int   base2;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [7:0] anodes [8];

    seg7_scan_if bus ();

    seg7_scan #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .SYS_reset  (SYS_reset),
        .disp_value (bus.disp_value),
        .disp_load  (bus.disp_load),
        .dp_mask    (bus.dp_mask),
        .blank_lz   (bus.blank_lz),
        .an_n       (bus.an_n),
        .seg_n      (bus.seg_n),
        .dp_n       (bus.dp_n),
        .scan_tick  (bus.scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input bit [127:0] nm, input logic [7:0] an,
                        input logic [6:0] sg, input logic dp, input logic tk);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.an   = an;
        e.seg  = sg;
        e.dp   = dp;
        e.tick = tk;
        sb.push_back(e);
    endtask

    // Slot j of digit d in scan round r after the last reset release.
    task automatic push_digit(input int r, input int d, input int j, input bit [127:0] nm,
                              input logic [6:0] sg, input logic dp);
        int c;
        c = base + 1 + 32*r + 4*d + j;
        if (j == 0) push(c, nm, 8'hFF, 7'h7F, 1'b1, 1'b0);
        else        push(c, nm, anodes[d], sg, dp, (j == 3));
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [31:0] v, input logic [7:0] dpm, input logic blz);
        bus.disp_value = v;
        bus.dp_mask    = dpm;
        bus.blank_lz   = blz;
        bus.disp_load  = 1'b1;
        @(posedge clk);
        #1;
        bus.disp_load  = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc <= cyc) begin
                checks++;
                if (sb[i].cyc < cyc) begin
                    errors++;
                    $display("FAIL %0s cyc %0d: check was not reached in its cycle", sb[i].name, sb[i].cyc);
                end else if (bus.an_n !== sb[i].an || bus.seg_n !== sb[i].seg ||
                             bus.dp_n !== sb[i].dp || bus.scan_tick !== sb[i].tick) begin
                    errors++;
                    $display("FAIL %0s cyc %0d: got an_n=%h seg_n=%h dp_n=%b tick=%b, want an_n=%h seg_n=%h dp_n=%b tick=%b",
                             sb[i].name, cyc, bus.an_n, bus.seg_n, bus.dp_n, bus.scan_tick,
                             sb[i].an, sb[i].seg, sb[i].dp, sb[i].tick);
                end
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        anodes = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        SYS_reset      = 1'b1;
        bus.disp_value = '0;
        bus.disp_load  = 1'b0;
        bus.dp_mask    = '0;
        bus.blank_lz   = 1'b0;

        wait_until(2);
        push(2, "reset_init", 8'hFF, 7'h7F, 1'b1, 1'b0);
        wait_until(3);
        SYS_reset = 1'b0;
        base = 3;

        // Free-run scan: every digit 0..7 then wrap back to digit 0, blank shadow shows 0.
        for (int k = 1; k <= 36; k++) begin
            int ph;
            int d;
            ph = (k - 1) % 4;
            d  = ((k - 1) / 4) % 8;
            if (ph == 0) push(base + k, "scan_dead", 8'hFF, 7'h7F, 1'b1, 1'b0);
            else         push(base + k, "scan_drive", anodes[d], 7'h40, 1'b1, (ph == 3));
        end

        wait_until(base + 36);
        load(32'h12345678, 8'h00, 1'b0);
        push_digit(2, 0, 1, "decode_d0", 7'h00, 1'b1);
        push_digit(2, 2, 1, "decode_d2", 7'h02, 1'b1);
        push_digit(2, 5, 1, "decode_d5", 7'h30, 1'b1);
        push_digit(2, 7, 0, "decode_d7_dead", 7'h7F, 1'b1);
        push_digit(2, 7, 1, "decode_d7", 7'h79, 1'b1);

        wait_until(base + 96);
        load(32'h000000A0, 8'h00, 1'b1);
        push_digit(3, 0, 2, "blank_a0_d0", 7'h40, 1'b1);
        push_digit(3, 1, 2, "blank_a0_d1", 7'h08, 1'b1);
        for (int d = 2; d < 8; d++) push_digit(3, d, 2, "blank_a0_hi", 7'h7F, 1'b1);

        wait_until(base + 128);
        load(32'h00000000, 8'h00, 1'b1);
        push_digit(4, 0, 1, "blank_zero_d0", 7'h40, 1'b1);
        for (int d = 1; d < 8; d++) push_digit(4, d, 1, "blank_zero_hi", 7'h7F, 1'b1);

        // Mid-slot load on digit 3: old pattern stays for the load edge, new one the edge after.
        push_digit(5, 2, 1, "midload_d2", 7'h7F, 1'b1);
        push_digit(5, 3, 1, "midload_pre", 7'h7F, 1'b1);
        push_digit(5, 3, 2, "midload_edge", 7'h7F, 1'b1);
        push_digit(5, 3, 3, "midload_new", 7'h0E, 1'b1);
        push_digit(5, 4, 0, "midload_dead", 7'h7F, 1'b1);
        push_digit(5, 4, 3, "midload_d4", 7'h0E, 1'b1);
        wait_until(base + 174);
        load(32'hFFFFFFFF, 8'h00, 1'b1);

        wait_until(base + 192);
        load(32'hFFFFFFFF, 8'h81, 1'b1);
        for (int d = 0; d < 8; d++) begin
            push_digit(6, d, 0, "dp_dead", 7'h7F, 1'b1);
            push_digit(6, d, 1, "dp_drive", 7'h0E, (d == 0 || d == 7) ? 1'b0 : 1'b1);
        end

        // Reset in the middle of digit 5 must blank outputs before any clock edge.
        push_digit(7, 5, 1, "prereset_d5", 7'h0E, 1'b1);
        wait_until(base + 247);
        SYS_reset = 1'b1;
        push(base + 247, "reset_async", 8'hFF, 7'h7F, 1'b1, 1'b0);
        push(base + 248, "reset_hold", 8'hFF, 7'h7F, 1'b1, 1'b0);
        wait_until(base + 249);
        SYS_reset = 1'b0;
        base2 = base + 249;
        push(base2 + 1, "restart_dead", 8'hFF, 7'h7F, 1'b1, 1'b0);
        push(base2 + 2, "restart_d0", 8'hFE, 7'h40, 1'b1, 1'b0);
        push(base2 + 4, "restart_tick", 8'hFE, 7'h40, 1'b1, 1'b1);
        push(base2 + 5, "restart_dead1", 8'hFF, 7'h7F, 1'b1, 1'b0);
        push(base2 + 6, "restart_d1", 8'hFD, 7'h40, 1'b1, 1'b0);
        wait_until(base2 + 8);

        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %0s cyc %0d: expectation never compared", sb[i].name, sb[i].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
